imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 177 +++++++++++++++++
 tb/tb_imem_loader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction memory loader: receives a length-prefixed byte stream and writes
// 16-bit instruction words into memory while holding the CPU in reset.
module imem_loader #(
   parameter logic [15:0] BASE_ADDR   = 16'h0000,
   parameter int unsigned MAX_WORDS   = 128,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic        imem_we,
   output logic [15:0] imem_addr,
   output logic [15:0] imem_wdata,
   output logic        cpu_hold,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [15:0] words_written
);

   localparam int unsigned SW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT_CYC - 1);
   localparam logic [15:0]   MAX_N      = 16'(MAX_WORDS);

   typedef enum logic [2:0] {
      IDLE,
      LEN_HI,
      LEN_LO,
      DATA_HI,
      DATA_LO,
      WRITE,
      DONE,
      ERROR
   } state_t;

   state_t        state_q, state_d;
   logic [15:0]   n_q, n_d;
   logic [7:0]    word_hi_q, word_hi_d;
   logic [SW-1:0] stall_q, stall_d;
   logic          imem_we_q, imem_we_d;
   logic [15:0]   imem_addr_q, imem_addr_d;
   logic [15:0]   imem_wdata_q, imem_wdata_d;
   logic          cpu_hold_q, cpu_hold_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic [15:0]   words_written_q, words_written_d;
   logic          accept;
   logic [15:0]   len_full;

   assign byte_ready = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                       (state_q == DATA_HI) || (state_q == DATA_LO);
   assign accept     = byte_valid && byte_ready;
   assign len_full   = {n_q[15:8], byte_data};

   // Next-state, datapath and registered-output decode.
   // Registered outputs are decoded from state_d so they are valid in the
   // same cycle the FSM occupies the corresponding state.
   always_comb begin
      state_d         = state_q;
      n_d             = n_q;
      word_hi_d       = word_hi_q;
      stall_d         = stall_q;
      imem_addr_d     = imem_addr_q;
      imem_wdata_d    = imem_wdata_q;
      words_written_d = words_written_q;

      case (state_q)
         IDLE, DONE, ERROR: begin
            if (start) begin
               state_d         = LEN_HI;
               words_written_d = '0;
               stall_d         = '0;
            end
         end
         LEN_HI: begin
            if (accept) begin
               n_d[15:8] = byte_data;
               stall_d   = '0;
               state_d   = LEN_LO;
            end
         end
         LEN_LO: begin
            if (accept) begin
               n_d[7:0] = byte_data;
               stall_d  = '0;
               if ((len_full == 16'h0000) || (len_full > MAX_N)) state_d = ERROR;
               else                                              state_d = DATA_HI;
            end else if (stall_q == STALL_LAST) begin
               state_d = ERROR;
            end else begin
               stall_d = stall_q + 1'b1;
            end
         end
         DATA_HI: begin
            if (accept) begin
               word_hi_d = byte_data;
               stall_d   = '0;
               state_d   = DATA_LO;
            end else if (stall_q == STALL_LAST) begin
               state_d = ERROR;
            end else begin
               stall_d = stall_q + 1'b1;
            end
         end
         DATA_LO: begin
            if (accept) begin
               imem_wdata_d = {word_hi_q, byte_data};
               imem_addr_d  = BASE_ADDR + {words_written_q[14:0], 1'b0};
               stall_d      = '0;
               state_d      = WRITE;
            end else if (stall_q == STALL_LAST) begin
               state_d = ERROR;
            end else begin
               stall_d = stall_q + 1'b1;
            end
         end
         WRITE: begin
            words_written_d = words_written_q + 16'd1;
            if ((words_written_q + 16'd1) == n_q) state_d = DONE;
            else                                  state_d = DATA_HI;
         end
         default: state_d = IDLE;
      endcase

      imem_we_d  = (state_d == WRITE);
      busy_d     = (state_d == LEN_HI) || (state_d == LEN_LO) || (state_d == DATA_HI) ||
                   (state_d == DATA_LO) || (state_d == WRITE);
      done_d     = (state_d == DONE);
      err_d      = (state_d == ERROR);
      cpu_hold_d = (state_d != DONE);
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= IDLE;
         n_q             <= '0;
         word_hi_q       <= '0;
         stall_q         <= '0;
         imem_we_q       <= 1'b0;
         imem_addr_q     <= '0;
         imem_wdata_q    <= '0;
         cpu_hold_q      <= 1'b1;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         err_q           <= 1'b0;
         words_written_q <= '0;
      end else begin
         state_q         <= state_d;
         n_q             <= n_d;
         word_hi_q       <= word_hi_d;
         stall_q         <= stall_d;
         imem_we_q       <= imem_we_d;
         imem_addr_q     <= imem_addr_d;
         imem_wdata_q    <= imem_wdata_d;
         cpu_hold_q      <= cpu_hold_d;
         busy_q          <= busy_d;
         done_q          <= done_d;
         err_q           <= err_d;
         words_written_q <= words_written_d;
      end
   end

   assign imem_we       = imem_we_q;
   assign imem_addr     = imem_addr_q;
   assign imem_wdata    = imem_wdata_q;
   assign cpu_hold      = cpu_hold_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign err           = err_q;
   assign words_written = words_written_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: frame loads, backpressure, bad lengths,
// inter-byte timeout, mid-load reset and restart behaviour.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        imem_we;
   logic [15:0] imem_addr;
   logic [15:0] imem_wdata;
   logic        cpu_hold;
   logic        busy;
   logic        done;
   logic        err;
   logic [15:0] words_written;

   int total = 0;
   int bad   = 0;

   logic [15:0] wa[$];
   logic [15:0] wd[$];
   logic [7:0]  frame[$];

   imem_loader #(
      .BASE_ADDR   (16'h0000),
      .MAX_WORDS   (128),
      .TIMEOUT_CYC (1024)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .byte_valid    (byte_valid),
      .byte_data     (byte_data),
      .byte_ready    (byte_ready),
      .imem_we       (imem_we),
      .imem_addr     (imem_addr),
      .imem_wdata    (imem_wdata),
      .cpu_hold      (cpu_hold),
      .busy          (busy),
      .done          (done),
      .err           (err),
      .words_written (words_written)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Record every memory write; the loader must never offer a byte slot while writing.
   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         wa.push_back(imem_addr);
         wd.push_back(imem_wdata);
         check("ready_in_write", {31'b0, byte_ready}, 32'd0);
      end
   end

   // Called at a negedge; returns at the negedge after the accepting posedge.
   task automatic send_byte(input logic [7:0] b, input bit hold);
      int n;
      n          = 0;
      byte_data  = b;
      byte_valid = 1'b1;
      while (byte_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("ready_wait", {31'b0, byte_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      if (!hold) byte_valid = 1'b0;
   endtask

   task automatic send_frame(input bit hold, input int gap);
      for (int i = 0; i < frame.size(); i++) begin
         send_byte(frame[i], hold);
         if (gap > 0) begin
            byte_valid = 1'b0;
            repeat (gap) @(negedge clk);
         end
      end
   endtask

   task automatic idle(input int n);
      byte_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic check_wr(input int idx, input logic [15:0] a, input logic [15:0] d);
      if (idx < wa.size()) begin
         check("wr_addr", {16'h0, wa[idx]}, {16'h0, a});
         check("wr_data", {16'h0, wd[idx]}, {16'h0, d});
      end else begin
         check("wr_missing", wa.size(), idx + 1);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_we", imem_we, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_busy", busy, 0);
      check("rst_ww", words_written, 0);
      check("rst_hold", cpu_hold, 1);
      check("rst_ready", byte_ready, 0);
      rst = 1'b0;
      idle(3);
      check("idle_hold", cpu_hold, 1);
      check("idle_busy", busy, 0);

      // Normal load with gaps between bytes
      wa.delete(); wd.delete();
      pulse_start();
      check("start_busy", busy, 1);
      check("start_hold", cpu_hold, 1);
      frame = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00};
      send_frame(1'b0, 2);
      send_byte(8'h07, 1'b0);
      check("lat_we", imem_we, 1);
      check("lat_addr", imem_addr, 16'h0004);
      check("lat_data", imem_wdata, 16'h0007);
      check("lat_done_early", done, 0);
      @(negedge clk);
      check("norm_done", done, 1);
      check("norm_hold", cpu_hold, 0);
      check("norm_busy", busy, 0);
      check("norm_err", err, 0);
      check("norm_ww", words_written, 3);
      check("norm_nwr", wa.size(), 3);
      check_wr(0, 16'h0000, 16'h1234);
      check_wr(1, 16'h0002, 16'hABCD);
      check_wr(2, 16'h0004, 16'h0007);

      // Restart from DONE, with a start pulse in DATA_HI that must be ignored
      wa.delete(); wd.delete();
      pulse_start();
      check("rs_done_clr", done, 0);
      check("rs_ww_clr", words_written, 0);
      check("rs_hold", cpu_hold, 1);
      frame = '{8'h00, 8'h02, 8'hAA, 8'h55};
      send_frame(1'b0, 0);
      idle(1);
      pulse_start();
      check("ign_ww", words_written, 1);
      check("ign_busy", busy, 1);
      check("ign_ready", byte_ready, 1);
      frame = '{8'h66, 8'h77};
      send_frame(1'b0, 0);
      idle(1);
      check("ign_done", done, 1);
      check("ign_ww2", words_written, 2);
      check("ign_nwr", wa.size(), 2);
      check_wr(0, 16'h0000, 16'hAA55);
      check_wr(1, 16'h0002, 16'h6677);

      // Backpressure: byte_valid held high for the whole frame
      wa.delete(); wd.delete();
      pulse_start();
      frame = '{8'h00, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'hFF};
      send_frame(1'b1, 0);
      send_byte(8'hFE, 1'b1);
      idle(1);
      check("bp_done", done, 1);
      check("bp_ww", words_written, 4);
      check("bp_nwr", wa.size(), 4);
      check_wr(0, 16'h0000, 16'hDEAD);
      check_wr(1, 16'h0002, 16'hBEEF);
      check_wr(2, 16'h0004, 16'h0102);
      check_wr(3, 16'h0006, 16'hFFFE);

      // Bad length N = 0
      wa.delete(); wd.delete();
      pulse_start();
      frame = '{8'h00, 8'h00};
      send_frame(1'b0, 0);
      check("n0_err", err, 1);
      check("n0_hold", cpu_hold, 1);
      check("n0_busy", busy, 0);
      check("n0_done", done, 0);
      idle(2);
      check("n0_err_stay", err, 1);
      check("n0_nwr", wa.size(), 0);

      // Bad length N = 0x0081 (one above MAX_WORDS)
      pulse_start();
      check("n81_err_clr", err, 0);
      frame = '{8'h00, 8'h81};
      send_frame(1'b0, 0);
      check("n81_err", err, 1);
      check("n81_hold", cpu_hold, 1);
      check("n81_busy", busy, 0);
      idle(2);
      check("n81_nwr", wa.size(), 0);

      // N = 0x0080 is legal; reset asserted in DATA_LO after one word
      pulse_start();
      frame = '{8'h00, 8'h80};
      send_frame(1'b0, 0);
      check("n80_err", err, 0);
      check("n80_busy", busy, 1);
      frame = '{8'h12, 8'h34};
      send_frame(1'b0, 0);
      idle(1);
      send_byte(8'h56, 1'b0);
      check("mid_ww", words_written, 1);
      rst = 1'b1;
      #1;
      check("arst_we", imem_we, 0);
      check("arst_busy", busy, 0);
      check("arst_ww", words_written, 0);
      check("arst_hold", cpu_hold, 1);
      check("arst_ready", byte_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      idle(2);
      check("post_rst_busy", busy, 0);
      check("post_rst_hold", cpu_hold, 1);
      check("mid_nwr", wa.size(), 1);
      check_wr(0, 16'h0000, 16'h1234);

      wa.delete(); wd.delete();
      pulse_start();
      frame = '{8'h00, 8'h01, 8'hCA, 8'hFE};
      send_frame(1'b0, 0);
      idle(1);
      check("rl_done", done, 1);
      check("rl_ww", words_written, 1);
      check("rl_nwr", wa.size(), 1);
      check_wr(0, 16'h0000, 16'hCAFE);

      // Timeout after one word and a lone high byte
      wa.delete(); wd.delete();
      pulse_start();
      frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h55};
      send_frame(1'b0, 0);
      repeat (1023) @(negedge clk);
      check("to_err_early", err, 0);
      check("to_busy_early", busy, 1);
      @(negedge clk);
      check("to_err", err, 1);
      check("to_ww", words_written, 1);
      check("to_hold", cpu_hold, 1);
      check("to_busy", busy, 0);
      check("to_nwr", wa.size(), 1);
      check_wr(0, 16'h0000, 16'h1234);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
